// File: rtl/adc_conv_scheduler_if.sv
// adc_conv_scheduler_if: requester and conversion-engine signals of the ADC scheduler
interface adc_conv_scheduler_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]   req;
  logic [2*NUM_REQ-1:0] req_ch;
  logic [NUM_REQ-1:0]   req_diff;
  logic [NUM_REQ-1:0]   ack;
  logic [11:0]          result;
  logic                 result_err;
  logic                 busy;
  logic [1:0]           grant_id;
  logic                 conv_start;
  logic [1:0]           conv_ch;
  logic                 conv_sgl;
  logic                 conv_done;
  logic [11:0]          conv_data;
  modport slave (
    input  req, req_ch, req_diff, conv_done, conv_data,
    output ack, result, result_err, busy, grant_id, conv_start, conv_ch, conv_sgl
  );
  modport master (
    output req, req_ch, req_diff, conv_done, conv_data,
    input  ack, result, result_err, busy, grant_id, conv_start, conv_ch, conv_sgl
  );
endinterface

// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler: round-robin sharing of one SPI ADC engine with CS gap and watchdog
module adc_conv_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 500,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input logic clk,
  input logic rst,
  adc_conv_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, WAIT, DELIVER, GAP} state_t;
  state_t      r_state;
  logic [1:0]  r_ptr, r_grant, r_ch;
  logic        r_sgl, r_start, r_busy, r_err;
  logic [11:0] r_result;
  logic [15:0] r_tmo;
  logic [9:0]  r_gap;
  logic [3:0]  w_req, w_diff;
  logic [7:0]  w_ch;
  logic [2:0]  w_idx;
  logic [1:0]  w_sel;
  assign w_req  = 4'(bus.req);
  assign w_diff = 4'(bus.req_diff);
  assign w_ch   = 8'(bus.req_ch);
  // r_ptr holds the index the next search starts from, so lower k wins
  always_comb begin
    w_sel = '0;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = 3'(r_ptr) + 3'(k);
      if (w_idx >= 3'(NUM_REQ)) w_idx = w_idx - 3'(NUM_REQ);
      if (w_req[w_idx[1:0]]) w_sel = w_idx[1:0];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_grant  <= '0;
      r_ch     <= '0;
      r_sgl    <= 1'b0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_tmo    <= '0;
      r_gap    <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: if (|w_req) begin
          r_grant <= w_sel;
          r_ch    <= w_ch[{w_sel, 1'b0} +: 2];
          r_sgl   <= ~w_diff[w_sel];
          r_start <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= START;
        end
        START: begin
          r_tmo   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_tmo <= r_tmo + 16'd1;
          if (bus.conv_done || r_tmo == 16'(TIMEOUT_CYCLES - 1)) begin
            r_result <= bus.conv_done ? bus.conv_data : '0;
            r_err    <= ~bus.conv_done;
            r_state  <= DELIVER;
          end
        end
        DELIVER: begin
          r_ptr   <= (r_grant == 2'(NUM_REQ - 1)) ? 2'd0 : r_grant + 2'd1;
          r_gap   <= '0;
          r_state <= GAP;
        end
        GAP: begin
          r_gap <= r_gap + 10'd1;
          if (r_gap == 10'(GAP_CYCLES - 1)) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // a requester that withdrew before DELIVER gets no ack
  assign bus.ack        = (r_state == DELIVER && w_req[r_grant]) ? NUM_REQ'(4'b1 << r_grant) : '0;
  assign bus.result     = r_result;
  assign bus.result_err = r_err;
  assign bus.busy       = r_busy;
  assign bus.grant_id   = r_grant;
  assign bus.conv_start = r_start;
  assign bus.conv_ch    = r_ch;
  assign bus.conv_sgl   = r_sgl;
endmodule

// File: tb/tb_adc_conv_scheduler.sv
// tb_adc_conv_scheduler: directed checks of arbitration, timing, timeout, withdrawal and reset
module tb_adc_conv_scheduler;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  adc_conv_scheduler_if a ();
  adc_conv_scheduler_if b ();
  adc_conv_scheduler dut_a (.clk(clk), .rst(rst), .bus(a));
  adc_conv_scheduler #(.TIMEOUT_CYCLES(64), .GAP_CYCLES(20)) dut_b (.clk(clk), .rst(rst), .bus(b));
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  // requester i asks for channel 3-i; conversion done lat cycles after conv_start
  task automatic xact(input int ew, input logic [1:0] eg, input int lat, input logic [11:0] d,
                      input logic drop, input logic [3:0] nxt);
    int n;
    n = 0;
    while (a.conv_start !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk("start_wait", n, ew);
    chk("grant", a.grant_id, eg);
    chk("conv_ch", a.conv_ch, 3 - eg);
    chk("conv_sgl", a.conv_sgl, !a.req_diff[eg]);
    tick();
    if (drop) a.req[eg] = 1'b0;
    repeat (lat - 1) tick();
    a.conv_done = 1'b1;
    a.conv_data = d;
    tick();
    a.conv_done = 1'b0;
    chk("ack", a.ack, drop ? 4'b0 : 4'(1) << eg);
    chk("result", a.result, d);
    chk("result_err", a.result_err, 0);
    if (!drop) a.req[eg] = 1'b0;
    tick();
    a.req = nxt;
  endtask
  initial begin
    int n;
    logic [3:0] acks;
    rst = 1'b1;
    a.req = '0; a.req_ch = '0; a.req_diff = '0; a.conv_done = 1'b0; a.conv_data = '0;
    b.req = '0; b.req_ch = '0; b.req_diff = '0; b.conv_done = 1'b0; b.conv_data = '0;
    tick();
    tick();
    chk("rst_ack", a.ack, 0);
    chk("rst_result", a.result, 0);
    chk("rst_err", a.result_err, 0);
    chk("rst_busy", a.busy, 0);
    chk("rst_grant", a.grant_id, 0);
    chk("rst_start", a.conv_start, 0);
    chk("rst_ch", a.conv_ch, 0);
    chk("rst_sgl", a.conv_sgl, 0);
    rst = 1'b0;
    tick();
    a.req_ch = 8'b00_00_00_10;
    a.req = 4'b0001;
    tick();
    chk("t1_start", a.conv_start, 1);
    chk("t1_ch", a.conv_ch, 2);
    chk("t1_sgl", a.conv_sgl, 1);
    chk("t1_busy", a.busy, 1);
    tick();
    chk("t1_start_pulse", a.conv_start, 0);
    repeat (99) tick();
    a.conv_done = 1'b1;
    a.conv_data = 12'hA5C;
    tick();
    a.conv_done = 1'b0;
    chk("t1_ack", a.ack, 4'b0001);
    chk("t1_result", a.result, 12'hA5C);
    chk("t1_err", a.result_err, 0);
    a.req = '0;
    repeat (500) tick();
    chk("t1_gap_busy", a.busy, 1);
    chk("t1_gap_ack", a.ack, 0);
    tick();
    chk("t1_idle_busy", a.busy, 0);
    b.req_ch = 8'b00_01_10_11;
    b.req = 4'b0010;
    n = 0;
    while (b.conv_start !== 1'b1 && n < 100) begin tick(); n++; end
    chk("t3_start_wait", n, 1);
    chk("t3_grant", b.grant_id, 1);
    chk("t3_ch", b.conv_ch, 2);
    repeat (64) tick();
    chk("t3_pre_timeout", b.ack, 0);
    tick();
    chk("t3_ack", b.ack, 4'b0010);
    chk("t3_result", b.result, 0);
    chk("t3_err", b.result_err, 1);
    b.req = 4'b0001;
    n = 0;
    while (b.conv_start !== 1'b1 && n < 200) begin tick(); n++; end
    chk("t4_start_wait", n, 22);
    chk("t4_grant", b.grant_id, 0);
    repeat (64) tick();
    b.conv_done = 1'b1;
    b.conv_data = 12'h123;
    tick();
    b.conv_done = 1'b0;
    chk("t4_ack", b.ack, 4'b0001);
    chk("t4_result", b.result, 12'h123);
    chk("t4_err", b.result_err, 0);
    b.req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a.req_ch = 8'b00_01_10_11;
    a.req_diff = 4'b0101;
    a.req = 4'b1111;
    xact(1, 2'd0, 10, 12'h111, 1'b0, 4'b1111);
    xact(501, 2'd1, 20, 12'h222, 1'b0, 4'b1111);
    xact(501, 2'd2, 30, 12'h333, 1'b0, 4'b1111);
    xact(501, 2'd3, 40, 12'h444, 1'b0, 4'b1111);
    xact(501, 2'd0, 50, 12'h555, 1'b0, 4'b1100);
    xact(501, 2'd2, 20, 12'h2AA, 1'b1, 4'b1000);
    xact(501, 2'd3, 25, 12'h3BB, 1'b0, 4'b0000);
    a.req = 4'b1000;
    n = 0;
    while (a.conv_start !== 1'b1 && n < 2000) begin tick(); n++; end
    chk("t6_start_wait", n, 501);
    chk("t6_grant", a.grant_id, 3);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", a.busy, 0);
    chk("t6_rst_grant", a.grant_id, 0);
    chk("t6_rst_ch", a.conv_ch, 0);
    chk("t6_rst_sgl", a.conv_sgl, 0);
    chk("t6_rst_result", a.result, 0);
    chk("t6_rst_ack", a.ack, 0);
    a.req = '0;
    tick();
    rst = 1'b0;
    tick();
    a.conv_done = 1'b1;
    a.conv_data = 12'hFFF;
    tick();
    a.conv_done = 1'b0;
    acks = '0;
    repeat (10) begin tick(); acks |= a.ack; end
    chk("t6_no_ack", acks, 0);
    chk("t6_stray_result", a.result, 0);
    chk("t6_idle_busy", a.busy, 0);
    a.req = 4'b1110;
    xact(1, 2'd1, 15, 12'h7E7, 1'b0, 4'b0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
